// File: rtl/jt51_exp2lin_rx.sv
// Serial floating-point DAC receiver: collects 13-bit mantissa/exponent words and
// converts them to 16-bit signed linear left/right samples on strobe falling edges.
module jt51_exp2lin_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        sd,
    input  logic        sh1,
    input  logic        sh2,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        left_vld,
    output logic        right_vld,
    output logic        frame_err
);

    logic [12:0] r_sr;
    logic [3:0]  r_cnt;
    logic        r_sh1;
    logic        r_sh2;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic        r_left_vld;
    logic        r_right_vld;
    logic        r_frame_err;

    logic        w_fall1;
    logic        w_fall2;
    logic        w_full;
    logic [2:0]  w_shamt;
    logic [15:0] w_mant_ext;
    logic [15:0] w_lin;

    always_comb begin
        w_fall1 = cen && r_sh1 && !sh1;
        w_fall2 = cen && r_sh2 && !sh2;
        w_full  = (r_cnt >= 4'd13);
    end

    // Decode always works on the word held before this cycle's shift.
    always_comb begin
        w_mant_ext = {{6{r_sr[9]}}, r_sr[9:0]};
        w_shamt    = r_sr[12:10] - 3'd1;
        w_lin      = '0;
        if (r_sr[12:10] != 3'd0) begin
            w_lin = w_mant_ext << w_shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_sh1       <= 1'b1;
            r_sh2       <= 1'b1;
            r_left      <= '0;
            r_right     <= '0;
            r_left_vld  <= 1'b0;
            r_right_vld <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_left_vld  <= 1'b0;
            r_right_vld <= 1'b0;
            r_frame_err <= 1'b0;
            if (cen) begin
                r_sr  <= {sd, r_sr[12:1]};
                r_sh1 <= sh1;
                r_sh2 <= sh2;
                if (w_fall1 || w_fall2) begin
                    r_cnt <= 4'd1;
                end else if (r_cnt != 4'd15) begin
                    r_cnt <= r_cnt + 4'd1;
                end
                if ((w_fall1 || w_fall2) && !w_full) begin
                    r_frame_err <= 1'b1;
                end
                if (w_fall1 && w_full) begin
                    r_left     <= w_lin;
                    r_left_vld <= 1'b1;
                end
                if (w_fall2 && w_full) begin
                    r_right     <= w_lin;
                    r_right_vld <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        left      = r_left;
        right     = r_right;
        left_vld  = r_left_vld;
        right_vld = r_right_vld;
        frame_err = r_frame_err;
    end

endmodule

// File: tb/tb_jt51_exp2lin_rx.sv
// Directed bench for jt51_exp2lin_rx: table of frames plus reset and cen-gating sequences.
module tb_jt51_exp2lin_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        sd;
    logic        sh1;
    logic        sh2;
    logic [15:0] left;
    logic [15:0] right;
    logic        left_vld;
    logic        right_vld;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    jt51_exp2lin_rx dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .sd        (sd),
        .sh1       (sh1),
        .sh2       (sh2),
        .left      (left),
        .right     (right),
        .left_vld  (left_vld),
        .right_vld (right_vld),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  mant;
        logic [2:0]  expo;
        int          nbits;
        logic        s1;
        logic        s2;
        logic [15:0] exp_left;
        logic [15:0] exp_right;
        logic        exp_lv;
        logic        exp_rv;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One cen-qualified clock, followed by a cen=0 half so pulses are observable.
    task automatic bit_cycle(input logic b, input logic s1, input logic s2);
        @(negedge clk);
        cen = 1'b1;
        sd  = b;
        sh1 = s1;
        sh2 = s2;
        @(negedge clk);
        cen = 1'b0;
    endtask

    // Junk ones first when nbits > 13, so the last 13 bits form the word.
    task automatic send_word(input logic [12:0] w, input int nbits);
        if (nbits >= 13) begin
            for (int i = 0; i < nbits - 13; i++) bit_cycle(1'b1, 1'b1, 1'b1);
            for (int i = 0; i < 13; i++) bit_cycle(w[i], 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < nbits; i++) bit_cycle(w[i], 1'b1, 1'b1);
        end
    endtask

    task automatic check_pulses(input string tag, input logic lv, input logic rv,
                                input logic er);
        check({tag, " left_vld"}, {15'd0, left_vld}, {15'd0, lv});
        check({tag, " right_vld"}, {15'd0, right_vld}, {15'd0, rv});
        check({tag, " frame_err"}, {15'd0, frame_err}, {15'd0, er});
    endtask

    initial begin
        vecs[0] = '{10'h200, 3'd7, 13, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{10'h1FF, 3'd7, 13, 1'b0, 1'b1, 16'h8000, 16'h7FC0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{10'h3FF, 3'd1, 13, 1'b0, 1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{10'h155, 3'd0, 13, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{10'h155, 3'd3, 13, 1'b1, 1'b0, 16'h0554, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{10'h0AA, 3'd5, 8,  1'b1, 1'b0, 16'h0554, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{10'h1FF, 3'd7, 13, 1'b1, 1'b0, 16'h7FC0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{10'h001, 3'd2, 16, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        cen = 1'b0;
        sd  = 1'b0;
        sh1 = 1'b1;
        sh2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset left", left, 16'h0000);
        check("reset right", right, 16'h0000);
        check_pulses("reset", 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            send_word({vecs[v].expo, vecs[v].mant}, vecs[v].nbits);
            bit_cycle(1'b0, !vecs[v].s1, !vecs[v].s2);
            check({tag, " left"}, left, vecs[v].exp_left);
            check({tag, " right"}, right, vecs[v].exp_right);
            check_pulses(tag, vecs[v].exp_lv, vecs[v].exp_rv, vecs[v].exp_err);
            @(negedge clk);
            check_pulses({tag, " next"}, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-frame with a simultaneous strobe edge: reset must win.
        send_word(13'h1555, 7);
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b1;
        sh1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b0;
        sh1 = 1'b1;
        check("rst left", left, 16'h0000);
        check("rst right", right, 16'h0000);
        check_pulses("rst", 1'b0, 1'b0, 1'b0);
        send_word({3'd3, 10'h155}, 13);
        bit_cycle(1'b0, 1'b0, 1'b1);
        check("post-rst left", left, 16'h0554);
        check_pulses("post-rst", 1'b1, 1'b0, 1'b0);

        // Strobe low while cen=0 is ignored until a cen cycle samples it.
        send_word({3'd7, 10'h200}, 13);
        @(negedge clk);
        sh1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_pulses("cen-low", 1'b0, 1'b0, 1'b0);
            check("cen-low left", left, 16'h0554);
        end
        bit_cycle(1'b0, 1'b0, 1'b1);
        check("cen-gated left", left, 16'h8000);
        check("cen-gated right", right, 16'h0000);
        check_pulses("cen-gated", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_pulses("cen-gated next", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
